// File: rtl/npc_mem_arbiter.sv
// npc_mem_arbiter: shares one memory port between IFU and LSU, one transaction in flight.
// Define NPC_ARB_RR_EN for round-robin contention handling (default build: LSU always wins).
module npc_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_resp_data,
    output logic              ifu_resp_err,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic              lsu_req_wen,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    input  logic [3:0]        lsu_req_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_resp_data,
    output logic              lsu_resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [3:0]        mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    // Last RESP cycle in which a response is still accepted before the timeout fires.
    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYC - 1);

    logic [1:0]        r_state;
    logic [7:0]        r_cnt;
    logic              r_owner_lsu;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_wmask;
    logic              r_ifu_resp_valid;
    logic              r_ifu_resp_err;
    logic [DATA_W-1:0] r_ifu_resp_data;
    logic              r_lsu_resp_valid;
    logic              r_lsu_resp_err;
    logic [DATA_W-1:0] r_lsu_resp_data;

    logic              w_idle;
    logic              w_grant_lsu;
    logic              w_accept;
    logic              w_resp_fire;
    logic [DATA_W-1:0] w_resp_data;

    assign w_idle        = (r_state == S_IDLE) && !reset;
    assign ifu_req_ready = w_idle && ifu_req_valid && !w_grant_lsu;
    assign lsu_req_ready = w_idle && w_grant_lsu;
    assign w_accept      = ifu_req_ready || lsu_req_ready;

`ifdef NPC_ARB_RR_EN
    logic r_last_lsu;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_lsu <= 1'b0;
        end else if (w_accept) begin
            r_last_lsu <= lsu_req_ready;
        end
    end

    // Under contention the requester that did not win last time takes the port.
    assign w_grant_lsu = lsu_req_valid && !(ifu_req_valid && r_last_lsu);
`else
    assign w_grant_lsu = lsu_req_valid;
`endif

    // A real response wins over a timeout landing in the same cycle.
    assign w_resp_fire = (r_state == S_RESP) && (mem_resp_valid || (r_cnt == LP_CNT_LAST));
    assign w_resp_data = (mem_resp_valid && !r_wen) ? mem_resp_data : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_cnt            <= 8'd0;
            r_owner_lsu      <= 1'b0;
            r_addr           <= '0;
            r_wen            <= 1'b0;
            r_wdata          <= '0;
            r_wmask          <= 4'd0;
            r_ifu_resp_valid <= 1'b0;
            r_ifu_resp_err   <= 1'b0;
            r_ifu_resp_data  <= '0;
            r_lsu_resp_valid <= 1'b0;
            r_lsu_resp_err   <= 1'b0;
            r_lsu_resp_data  <= '0;
        end else begin
            r_ifu_resp_valid <= 1'b0;
            r_ifu_resp_err   <= 1'b0;
            r_lsu_resp_valid <= 1'b0;
            r_lsu_resp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_owner_lsu <= lsu_req_ready;
                        r_addr      <= lsu_req_ready ? lsu_req_addr : ifu_req_addr;
                        r_wen       <= lsu_req_ready && lsu_req_wen;
                        r_wdata     <= lsu_req_ready ? lsu_req_wdata : '0;
                        r_wmask     <= lsu_req_ready ? lsu_req_wmask : 4'd0;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_cnt   <= 8'd0;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (r_cnt != 8'hFF) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                    if (w_resp_fire) begin
                        r_state <= S_IDLE;
                        if (r_owner_lsu) begin
                            r_lsu_resp_valid <= 1'b1;
                            r_lsu_resp_err   <= !mem_resp_valid;
                            r_lsu_resp_data  <= w_resp_data;
                        end else begin
                            r_ifu_resp_valid <= 1'b1;
                            r_ifu_resp_err   <= !mem_resp_valid;
                            r_ifu_resp_data  <= w_resp_data;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req_valid  = (r_state == S_REQ);
    assign mem_req_addr   = r_addr;
    assign mem_req_wen    = r_wen;
    assign mem_req_wdata  = r_wdata;
    assign mem_req_wmask  = r_wmask;

    assign ifu_resp_valid = r_ifu_resp_valid;
    assign ifu_resp_err   = r_ifu_resp_err;
    assign ifu_resp_data  = r_ifu_resp_data;
    assign lsu_resp_valid = r_lsu_resp_valid;
    assign lsu_resp_err   = r_lsu_resp_err;
    assign lsu_resp_data  = r_lsu_resp_data;

endmodule

// File: tb/tb_npc_mem_arbiter.sv
// Bench for npc_mem_arbiter: vector table, hand sequences (timeout, reset, contention) and random traffic.
module tb_npc_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_resp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen;
    logic [31:0] lsu_req_addr, lsu_req_wdata;
    logic [3:0]  lsu_req_wmask;
    logic        lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_resp_data;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    npc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    typedef struct {
        string       name;
        logic        iv;
        logic [31:0] ia;
        logic        lv;
        logic [31:0] la;
        logic        wen;
        logic [31:0] wd;
        logic [3:0]  wm;
        int          rdy;   // cycles mem_req_ready is held low
        int          resp;  // cycles in RESP before mem_resp_valid, -1 = never
        logic [31:0] rd;
        logic        exp_lsu;
        int          exp_lat;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        got_acc;
        logic        owner_lsu;
        int          lat_req;
        int          nreq;
        logic        fields_ok;
        logic        got_resp;
        logic        rowner_lsu;
        int          lat;
        logic [31:0] data;
        logic        err;
        int          pulses;
    } obs_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    function automatic vec_t mk(input string nm, input logic iv, input logic [31:0] ia,
                                input logic lv, input logic [31:0] la, input logic wen,
                                input logic [31:0] wd, input logic [3:0] wm, input int rdy,
                                input int resp, input logic [31:0] rd, input logic exp_lsu,
                                input int exp_lat, input logic [31:0] exp_data, input logic exp_err);
        vec_t v;
        v.name = nm; v.iv = iv; v.ia = ia; v.lv = lv; v.la = la; v.wen = wen; v.wd = wd;
        v.wm = wm; v.rdy = rdy; v.resp = resp; v.rd = rd; v.exp_lsu = exp_lsu;
        v.exp_lat = exp_lat; v.exp_data = exp_data; v.exp_err = exp_err;
        return v;
    endfunction

    // Reference: one requester, memory ready after rdy cycles, response after resp RESP cycles.
    function automatic void model(inout vec_t v);
        v.exp_lsu = v.lv;
        if (v.resp >= 0 && v.resp < TO) begin
            v.exp_lat  = v.rdy + v.resp + 3;
            v.exp_err  = 1'b0;
            v.exp_data = (v.lv && v.wen) ? 32'h0 : v.rd;
        end else begin
            v.exp_lat  = v.rdy + TO + 2;
            v.exp_err  = 1'b1;
            v.exp_data = 32'h0;
        end
    endfunction

    task automatic do_txn(input vec_t v, input logic noise, output obs_t o);
        o = '{default: 0};
        @(posedge clk); #1;
        ifu_req_valid = v.iv; ifu_req_addr = v.ia;
        lsu_req_valid = v.lv; lsu_req_addr = v.la; lsu_req_wen = v.wen;
        lsu_req_wdata = v.wd; lsu_req_wmask = v.wm;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        for (int i = 0; i < 5 && !o.got_acc; i++) begin
            @(negedge clk);
            if (ifu_req_valid && ifu_req_ready) begin o.got_acc = 1'b1; o.owner_lsu = 1'b0; end
            else if (lsu_req_valid && lsu_req_ready) begin o.got_acc = 1'b1; o.owner_lsu = 1'b1; end
            if (!o.got_acc) begin @(posedge clk); #1; end
        end
        if (!o.got_acc) begin
            ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
            return;
        end
        o.fields_ok = 1'b1;
        for (int c = 1; c <= 60 && !o.got_resp; c++) begin
            @(posedge clk); #1;
            ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
            mem_req_ready = (c == v.rdy + 1);
            if (c <= v.rdy + 1) begin
                mem_resp_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_resp_data  = $urandom;
            end else begin
                mem_resp_valid = (v.resp >= 0) && (c == v.rdy + 2 + v.resp);
                mem_resp_data  = v.rd;
            end
            @(negedge clk);
            if (mem_req_valid) begin
                o.nreq++;
                if (o.lat_req == 0) o.lat_req = c;
                if (mem_req_addr !== (o.owner_lsu ? v.la : v.ia) ||
                    mem_req_wen !== (o.owner_lsu && v.wen) ||
                    mem_req_wmask !== (o.owner_lsu ? v.wm : 4'h0) ||
                    (o.owner_lsu && mem_req_wdata !== v.wd))
                    o.fields_ok = 1'b0;
            end
            if (ifu_resp_valid) begin
                o.pulses++; o.got_resp = 1'b1; o.rowner_lsu = 1'b0;
                o.data = ifu_resp_data; o.err = ifu_resp_err; o.lat = c;
            end
            if (lsu_resp_valid) begin
                o.pulses++; o.got_resp = 1'b1; o.rowner_lsu = 1'b1;
                o.data = lsu_resp_data; o.err = lsu_resp_err; o.lat = c;
            end
        end
    endtask

    task automatic check_txn(input vec_t v, input obs_t o);
        chk({v.name, " accepted"}, 64'(o.got_acc), 64'd1);
        chk({v.name, " grant"}, 64'(o.owner_lsu), 64'(v.exp_lsu));
        chk({v.name, " mem_req latency"}, 64'(o.lat_req), 64'd1);
        chk({v.name, " mem_req cycles"}, 64'(o.nreq), 64'(v.rdy + 1));
        chk({v.name, " mem_req fields"}, 64'(o.fields_ok), 64'd1);
        chk({v.name, " resp seen"}, 64'(o.got_resp), 64'd1);
        chk({v.name, " resp owner"}, 64'(o.rowner_lsu), 64'(v.exp_lsu));
        chk({v.name, " resp latency"}, 64'(o.lat), 64'(v.exp_lat));
        chk({v.name, " resp data"}, 64'(o.data), 64'(v.exp_data));
        chk({v.name, " resp err"}, 64'(o.err), 64'(v.exp_err));
        chk({v.name, " pulse count"}, 64'(o.pulses), 64'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        vec_t tbl[7];
        vec_t v;
        obs_t o;
        int   ng, np;
        logic [2:0] g, exp_g;

        reset = 1'b1;
        ifu_req_valid = 0; ifu_req_addr = 0; lsu_req_valid = 0; lsu_req_addr = 0;
        lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wmask = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;

        tbl[0] = mk("ifu_read", 1, 32'h8000_0000, 0, 0, 0, 0, 4'h0, 0, 0, 32'h0000_0413, 0, 3, 32'h0000_0413, 0);
        tbl[1] = mk("lsu_write_stall", 0, 0, 1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 2, 0, 32'h1234_5678, 1, 5, 32'h0, 0);
        tbl[2] = mk("lsu_read", 0, 0, 1, 32'h8000_0010, 0, 32'h0, 4'h0, 1, 2, 32'hCAFE_F00D, 1, 6, 32'hCAFE_F00D, 0);
        tbl[3] = mk("ifu_timeout", 1, 32'h8000_0004, 0, 0, 0, 0, 4'h0, 0, -1, 32'h5555_5555, 0, 6, 32'h0, 1);
        tbl[4] = mk("lsu_last_chance", 0, 0, 1, 32'h8000_0020, 0, 0, 4'h0, 0, TO - 1, 32'hA5A5_A5A5, 1, 6, 32'hA5A5_A5A5, 0);
        tbl[5] = mk("lsu_write_timeout", 0, 0, 1, 32'h8000_0030, 1, 32'h0BAD_F00D, 4'h3, 3, -1, 32'h7777_7777, 1, 9, 32'h0, 1);
        tbl[6] = mk("ifu_resp_too_late", 1, 32'h8000_0040, 0, 0, 0, 0, 4'h0, 0, TO, 32'h9999_9999, 0, 6, 32'h0, 1);

        // Reset state, with both requesters asserting valid
        repeat (2) @(posedge clk);
        #1;
        ifu_req_valid = 1; lsu_req_valid = 1;
        #1;
        chk("reset readies", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
        chk("reset mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("reset mem_req fields", {mem_req_addr, mem_req_wdata} | 64'({mem_req_wen, mem_req_wmask}), 64'd0);
        chk("reset resp valid/err", {60'd0, ifu_resp_valid, ifu_resp_err, lsu_resp_valid, lsu_resp_err}, 64'd0);
        chk("reset resp data", {ifu_resp_data, lsu_resp_data}, 64'd0);
        ifu_req_valid = 0; lsu_req_valid = 0;
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (tbl[i]) begin
            do_txn(tbl[i], 1'b0, o);
            check_txn(tbl[i], o);
        end

        // Timeout followed by a late memory response one cycle after the error pulse
        do_txn(tbl[3], 1'b0, o);
        check_txn(tbl[3], o);
        @(posedge clk); #1;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h1111_2222;
        @(negedge clk);
        chk("late resp same cycle", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("late resp next cycle", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
        chk("late resp no mem_req", 64'(mem_req_valid), 64'd0);

        // Reset while an LSU read sits in RESP
        @(posedge clk); #1;
        lsu_req_valid = 1; lsu_req_addr = 32'h8000_2000; lsu_req_wen = 0; lsu_req_wmask = 0;
        ng = 0;
        for (int i = 0; i < 5 && ng == 0; i++) begin
            @(negedge clk);
            if (lsu_req_ready) ng = 1;
            else begin @(posedge clk); #1; end
        end
        chk("rst seq accept", 64'(ng), 64'd1);
        @(posedge clk); #1;
        mem_req_ready = 1;
        @(posedge clk); #1;
        mem_req_ready = 0;
        @(negedge clk);
        reset = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'hFEED_FACE;
        #1;
        chk("rst mid readies", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
        chk("rst mid mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst mid mem_req addr", 64'(mem_req_addr), 64'd0);
        chk("rst mid resp", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
        @(posedge clk); #1;
        lsu_req_valid = 0; mem_resp_valid = 0;
        @(negedge clk);
        reset = 1'b0;
        chk("rst release resp", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
        v = mk("ifu_after_reset", 1, 32'h8000_0100, 0, 0, 0, 0, 4'h0, 1, 0, 32'h0000_0093, 0, 0, 0, 0);
        model(v);
        do_txn(v, 1'b0, o);
        check_txn(v, o);

        // Contention: both requesters held valid, memory always ready and responding
        pulse_reset();
        ng = 0; np = 0; g = 3'b000;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            ifu_req_valid = (k < 9); lsu_req_valid = (k < 9);
            ifu_req_addr = 32'h8000_0200; lsu_req_addr = 32'h8000_0300; lsu_req_wen = 0;
            mem_req_ready = 1; mem_resp_valid = 1; mem_resp_data = 32'h0000_00AB;
            @(negedge clk);
            if (ifu_req_ready || lsu_req_ready) begin
                if (ng < 3) g[ng] = lsu_req_ready;
                ng++;
            end
            if (ifu_resp_valid || lsu_resp_valid) np++;
        end
        mem_req_ready = 0; mem_resp_valid = 0;
`ifdef NPC_ARB_RR_EN
        exp_g = 3'b101;
`else
        exp_g = 3'b111;
`endif
        chk("contention grant count", 64'(ng), 64'd3);
        chk("contention grant order", 64'(g), 64'(exp_g));
        chk("contention resp count", 64'(np), 64'd3);

        // Random single-requester traffic against the reference model, stale responses in REQ
        pulse_reset();
        for (int n = 0; n < 30; n++) begin
            v.name = $sformatf("rand%0d", n);
            v.lv   = 1'($urandom_range(0, 1));
            v.iv   = !v.lv;
            v.ia   = $urandom; v.la = $urandom;
            v.wen  = 1'($urandom_range(0, 1));
            v.wd   = $urandom; v.wm = 4'($urandom);
            v.rdy  = $urandom_range(0, 3);
            v.resp = int'($urandom_range(0, 6)) - 1;
            v.rd   = $urandom;
            model(v);
            do_txn(v, 1'b1, o);
            check_txn(v, o);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/npc_mem_arbiter.md
# npc_mem_arbiter

Two-requester memory arbiter for the NPC core. It shares the single memory port (DPI-C `npc_pmem_read`/`npc_pmem_write` wrapper) between the instruction fetch unit (IFU) and the load/store unit (LSU). One transaction is outstanding at a time, and every grant is held until its response returns or times out. It sits between the IFU/LSU and the memory wrapper in the multi-cycle core.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYC, 255, maximum cycles to wait for mem_resp_valid before an error response (1..255)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  ADDR_W  IFU read address
- ifu_resp_valid  out  1  IFU response pulse
- ifu_resp_data  out  DATA_W  IFU read data
- ifu_resp_err  out  1  IFU response is a timeout error
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_addr  in  ADDR_W  LSU address
- lsu_req_wen  in  1  1 = write, 0 = read
- lsu_req_wdata  in  DATA_W  write data
- lsu_req_wmask  in  4  byte write mask
- lsu_resp_valid  out  1  LSU response pulse (reads and writes)
- lsu_resp_data  out  DATA_W  LSU read data (0 for writes)
- lsu_resp_err  out  1  LSU response is a timeout error
- mem_req_valid  out  1  request to the memory wrapper
- mem_req_ready  in  1  memory accepts the request
- mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask  out  ADDR_W/1/DATA_W/4  latched request fields
- mem_resp_valid  in  1  memory response pulse
- mem_resp_data  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, REQ, RESP.
- **IDLE**:
  - Combinationally grants one valid requester: `*_req_ready` = 1 for the winner only.
  - On accept (valid && ready), latches the address, wen, wdata, wmask and owner, then moves to REQ.
  - IFU requests are latched with wen = 0 and wmask = 0.
- **REQ**:
  - Drives mem_req_valid = 1 with the latched fields, held stable.
  - On mem_req_ready = 1, clears the timeout counter and moves to RESP.
- **RESP**:
  - Counter increments each cycle.
  - On mem_resp_valid, registers mem_resp_data to the owner's resp_data (forced to 0 for writes), pulses the owner's resp_valid with err = 0, and returns to IDLE.
  - If the counter reaches TIMEOUT_CYC with no response, pulses the owner's resp_valid with err = 1 and data = 0, then returns to IDLE.
- mem_resp_valid in IDLE or REQ is a stale or late response: ignored, no output effect.
- Response outputs have no back-pressure. Requesters must accept a resp_valid pulse in the cycle it appears.
- Arbitration with no contention: the sole valid requester wins.
- Arbitration under contention: see Configuration.
- The non-winning requester's ready stays 0. Its request must be held until accepted.
- Reset mid-operation: the FSM returns to IDLE and any in-flight transaction is discarded with no response pulse.

## Timing
- Reset values:
  - state = IDLE, counter = 0, last_grant = IFU.
  - All valid, ready and err outputs = 0; resp_data = 0; mem_req_* = 0.
  - Ready outputs are forced to 0 while reset is high.
- Accept in cycle N → mem_req_valid high in N+1.
- mem_req_ready in cycle M → state is RESP in M+1.
- mem_resp_valid in cycle K → owner resp_valid in K+1, one cycle wide. The next request can be accepted in K+1, since IDLE is entered at the same edge.
- Minimum round trip, request accept to resp_valid: 3 cycles, with mem_req_ready and mem_resp_valid each asserted on the first eligible cycle.
- Timeout: resp_valid/err appear TIMEOUT_CYC+1 cycles after the cycle that moved the FSM into RESP.
- The counter is 8 bits and saturates; it never wraps.

## Configuration
- `NPC_ARB_RR_EN` defined: round-robin arbitration.
  - On contention, grant the requester not in last_grant.
  - last_grant updates on every accept.
  - From reset, the first contention goes to the LSU.
- Not defined: fixed priority, LSU always wins contention. last_grant is unused.

## Test plan
- Single IFU read, addr 0x80000000, memory ready and responds immediately with 0x00000413 → ifu_resp_valid 3 cycles after accept, data 0x00000413, err 0, lsu_resp_valid stays 0.
- LSU write, addr 0x80001000, wdata 0xDEADBEEF, wmask 4'b1111, memory stalls ready 2 cycles → mem_req fields stable throughout the stall, lsu_resp_valid with data 0, err 0.
- Both valid in the same cycle for 3 transactions:
  - Without NPC_ARB_RR_EN: grants LSU, LSU, LSU while LSU stays valid.
  - With NPC_ARB_RR_EN: grants LSU, IFU, LSU.
- Memory never responds with TIMEOUT_CYC = 4 → ifu_resp_valid with err 1 and data 0, 5 cycles after RESP entry. A late mem_resp_valid one cycle later produces no pulse.
- Reset asserted during RESP of an LSU read → outputs 0 immediately. After release, a new IFU request is served normally with no stray lsu_resp_valid.
